dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory access controller between the CPU LW/SW path and a
// variable-latency memory. Optional `DMEM_ALIGN_CHK_EN faults odd addresses.
module dmem_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        stall,
    output logic        err,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valid
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic        wr_q;
    logic [14:0] addr_q;
    logic [15:0] wdata_q;
    logic [7:0]  cnt_q;
    logic [15:0] rdata_q;
    logic        err_q;

    logic        take;
    logic        misalign;
    logic        timeout;
    logic        fault;
    logic        capture;

`ifdef DMEM_ALIGN_CHK_EN
    assign misalign = cpu_addr[0];
`else
    // Byte offset is meaningless for word accesses; the word is still used.
    logic unused_addr_lsb;
    assign unused_addr_lsb = cpu_addr[0];
    assign misalign = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and combinational strobes.
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        take      = 1'b0;
        timeout   = 1'b0;
        capture   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_req) begin
                    stall = 1'b1;
                    take  = 1'b1;
                    state_nxt = misalign ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                stall  = 1'b1;
                mem_en = 1'b1;
                mem_wr = wr_q;
                if (mem_valid) begin
                    capture   = ~wr_q;
                    state_nxt = DONE;
                end else if (cnt_q == TO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign fault = timeout | (take & misalign);

    // Request latches, wait counter, load result and fault pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= fault;
            if (take) begin
                wr_q    <= cpu_wr;
                addr_q  <= cpu_addr[15:1];
                wdata_q <= cpu_wdata;
                cnt_q   <= '0;
            end else if (state == ACCESS && !mem_valid && !timeout) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (capture) begin
                rdata_q <= mem_rdata;
            end else if (fault) begin
                rdata_q <= 16'hFFFF;
            end
        end
    end

    assign cpu_rdata = rdata_q;
    assign err       = err_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule
